adder_byte_seq: RTL

ADDER_BYTE_SEQ -- requirements
Module: adder_byte_seq

---
 rtl/adder_byte_seq.sv | 137 +++++++++++++
 1 files changed

// File: rtl/adder_byte_seq.sv
// adder_byte_seq
//   Byte-serial multi-byte adder. Operands arrive one byte pair per beat,
//   least-significant byte first. Each accepted beat produces one result byte
//   one cycle later through a single output register with ready/valid
//   handshaking on both sides.
//
// Ports
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready input handshake (in_ready = !out_valid || out_ready)
//   in_first/in_last  word framing of the input beat
//   a, b, cin         operand bytes; cin is the word carry-in (first beats only)
//   out_valid/out_ready output handshake
//   sum, cout         result byte and its carry out
//   out_last, out_idx word framing of the result byte (idx 0 = LSB)
//   err, err_clr      sticky protocol-error flag and its clear
module adder_byte_seq #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_first,
    input  logic             in_last,
    input  logic [7:0]       a,
    input  logic [7:0]       b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       sum,
    output logic             cout,
    output logic             out_last,
    output logic [CNT_W-1:0] out_idx,
    output logic             err,
    input  logic             err_clr
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    localparam logic [CNT_W-1:0] IDX_MAX = {CNT_W{1'b1}};

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             err_q, err_d;

    logic             xfer_in;
    logic             first_eff;
    logic             proto_err;
    logic             overflow;
    logic             cin_eff;
    logic [CNT_W-1:0] idx_cur;
    logic [8:0]       res;

    assign in_ready = !out_valid_q || out_ready;
    assign xfer_in  = in_valid && in_ready;

    // A beat starts a word when flagged first, or when no word is open
    // (a missing first flag in IDLE is tolerated but reported).
    assign first_eff = in_first || (state_q == IDLE);
    assign proto_err = (state_q == IDLE) ? !in_first : in_first;
    assign idx_cur   = first_eff ? '0 : cnt_q;
    assign cin_eff   = first_eff ? cin : carry_q;
    assign res       = {1'b0, a} + {1'b0, b} + {8'b0, cin_eff};
    // Counter would run past the last representable index: close the word.
    assign overflow  = (idx_cur == IDX_MAX) && !in_last;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        last_d      = last_q;
        idx_d       = idx_q;
        err_d       = err_q;

        if (xfer_in) begin
            out_valid_d = 1'b1;
            sum_d       = res[7:0];
            cout_d      = res[8];
            last_d      = in_last || overflow;
            idx_d       = idx_cur;
            carry_d     = res[8];
            cnt_d       = idx_cur + 1'b1;  // wraps to 0 after IDX_MAX
            state_d     = (in_last || overflow) ? IDLE : ACTIVE;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        // Set has priority over clear.
        if (xfer_in && (proto_err || overflow)) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            out_valid_q <= 1'b0;
            sum_q       <= 8'h00;
            cout_q      <= 1'b0;
            last_q      <= 1'b0;
            idx_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            carry_q     <= carry_d;
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            last_q      <= last_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign out_last  = last_q;
    assign out_idx   = idx_q;
    assign err       = err_q;

endmodule
